// File: rtl/alg_edge_event_ctrl.sv
// rtl/alg_edge_event_ctrl.sv - multi-channel synchronised, glitch-filtered edge detector with sticky event flags
module alg_edge_event_ctrl #(
   parameter int              CH          = 8,
   parameter int              SYNC_STAGES = 2,
   parameter int              FILT_W      = 4,
   parameter logic [CH-1:0]   INIT_LEVEL  = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH-1:0]       sig,
   input  logic [FILT_W-1:0]   filt_len,
   input  logic [2*CH-1:0]     edge_mode,
   input  logic [CH-1:0]       evt_clr,
   output logic [CH-1:0]       level,
   output logic [CH-1:0]       rise,
   output logic [CH-1:0]       fall,
   output logic [CH-1:0]       evt_pend,
   output logic [CH-1:0]       evt_ovf,
   output logic                irq
);

   logic [CH-1:0]          sync_q [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] prime_q;
   logic [FILT_W-1:0]      cnt_q [CH];
   logic [CH-1:0]          s;
   logic                   primed;
   logic [CH-1:0]          rise_en;
   logic [CH-1:0]          fall_en;
   logic [CH-1:0]          ev;

   assign s      = sync_q[SYNC_STAGES-1];
   assign primed = prime_q[SYNC_STAGES-1];

   always_comb begin
      rise_en = '0;
      fall_en = '0;
      for (int i = 0; i < CH; i++) begin
         rise_en[i] = edge_mode[2*i];
         fall_en[i] = edge_mode[2*i+1];
      end
   end

   assign ev = (rise & rise_en) | (fall & fall_en);

   // The chain holds reset zeros until refilled; prime_q marks when s is real input data,
   // so a channel whose input already matches INIT_LEVEL never sees a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         prime_q <= '0;
      end else begin
         sync_q[0] <= sig;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= INIT_LEVEL;
         rise  <= '0;
         fall  <= '0;
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            rise[i] <= 1'b0;
            fall[i] <= 1'b0;
            if (!primed || (s[i] == level[i])) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] >= filt_len) begin
               level[i] <= s[i];
               cnt_q[i] <= '0;
               rise[i]  <= s[i];
               fall[i]  <= ~s[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + FILT_W'(1);
            end
         end
      end
   end

   // A new event beats a simultaneous clear; the clear only acknowledges the overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_pend <= '0;
         evt_ovf  <= '0;
         irq      <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (ev[i]) begin
               evt_pend[i] <= 1'b1;
               if (evt_clr[i]) begin
                  evt_ovf[i] <= 1'b0;
               end else if (evt_pend[i]) begin
                  evt_ovf[i] <= 1'b1;
               end
            end else if (evt_clr[i]) begin
               evt_pend[i] <= 1'b0;
               evt_ovf[i]  <= 1'b0;
            end
         end
         irq <= |evt_pend;
      end
   end

endmodule

// File: tb/tb_alg_edge_event_ctrl.sv
// tb/tb_alg_edge_event_ctrl.sv - directed self-checking bench for alg_edge_event_ctrl
module tb_alg_edge_event_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] sig;
   logic [3:0] filt_len;
   logic [7:0] edge_mode;
   logic [3:0] evt_clr;
   logic [3:0] level, rise, fall, evt_pend, evt_ovf;
   logic       irq;

   logic [3:0] sig_b;
   logic [3:0] filt_len_b;
   logic [7:0] edge_mode_b;
   logic [3:0] evt_clr_b;
   logic [3:0] level_b, rise_b, fall_b, evt_pend_b, evt_ovf_b;
   logic       irq_b;

   int         n_checks;
   int         n_errors;
   logic [3:0] acc;
   logic [3:0] b_seen;

   alg_edge_event_ctrl #(.CH(4), .SYNC_STAGES(2), .FILT_W(4), .INIT_LEVEL(4'h0)) dut (
      .clk(clk), .rst_n(rst_n), .sig(sig), .filt_len(filt_len), .edge_mode(edge_mode),
      .evt_clr(evt_clr), .level(level), .rise(rise), .fall(fall),
      .evt_pend(evt_pend), .evt_ovf(evt_ovf), .irq(irq)
   );

   alg_edge_event_ctrl #(.CH(4), .SYNC_STAGES(2), .FILT_W(4), .INIT_LEVEL(4'hF)) dut_hi (
      .clk(clk), .rst_n(rst_n), .sig(sig_b), .filt_len(filt_len_b), .edge_mode(edge_mode_b),
      .evt_clr(evt_clr_b), .level(level_b), .rise(rise_b), .fall(fall_b),
      .evt_pend(evt_pend_b), .evt_ovf(evt_ovf_b), .irq(irq_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      b_seen = b_seen | rise_b | fall_b | evt_pend_b | evt_ovf_b | {3'b000, irq_b};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic acc_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         acc = acc | rise | fall;
      end
   endtask

   task automatic clr(input logic [3:0] mask);
      evt_clr = mask;
      tick();
      evt_clr = 4'h0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      b_seen      = 4'h0;
      acc         = 4'h0;
      rst_n       = 1'b0;
      sig         = 4'h0;
      filt_len    = 4'd0;
      edge_mode   = 8'hFF;
      evt_clr     = 4'h0;
      sig_b       = 4'hF;
      filt_len_b  = 4'd0;
      edge_mode_b = 8'hFF;
      evt_clr_b   = 4'h0;

      ticks(3);
      chk("rst_level", level, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
      chk("rst_pend", evt_pend, 4'h0);
      chk("rst_ovf", evt_ovf, 4'h0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_level_hi", level_b, 4'hF);

      rst_n = 1'b1;
      ticks(6);

      // latency with filt_len = 0
      sig[0] = 1'b1;
      tick();
      tick();
      chk("lat_rise_early", rise, 4'h0);
      tick();
      chk("lat_rise", rise, 4'h1);
      chk("lat_level", level, 4'h1);
      tick();
      chk("lat_rise_once", rise, 4'h0);
      chk("lat_pend", evt_pend, 4'h1);
      chk("lat_irq_early", irq, 1'b0);
      tick();
      chk("lat_irq", irq, 1'b1);
      clr(4'h1);
      chk("clr0_pend", evt_pend, 4'h0);
      chk("clr0_irq_hold", irq, 1'b1);
      tick();
      chk("clr0_irq", irq, 1'b0);
      sig[0] = 1'b0;
      ticks(3);
      chk("fall0", fall, 4'h1);
      chk("fall0_level", level, 4'h0);
      tick();
      chk("fall0_pend", evt_pend, 4'h1);
      clr(4'h1);
      ticks(2);

      // glitch rejection with filt_len = 3
      filt_len = 4'd3;
      acc = 4'h0;
      sig[1] = 1'b1;
      acc_ticks(3);
      sig[1] = 1'b0;
      acc_ticks(8);
      chk("glitch_no_edge", acc, 4'h0);
      chk("glitch_level", level, 4'h0);
      acc = 4'h0;
      sig[1] = 1'b1;
      acc_ticks(4);
      sig[1] = 1'b0;
      acc_ticks(1);
      chk("filt_rise_early", acc, 4'h0);
      tick();
      chk("filt_rise", rise, 4'h2);
      ticks(5);
      chk("filt_ovf_after_fall", evt_ovf, 4'h2);
      chk("filt_level_back", level, 4'h0);
      clr(4'h2);
      chk("filt_clr_pend", evt_pend, 4'h0);
      chk("filt_clr_ovf", evt_ovf, 4'h0);
      ticks(2);

      // overflow and clear on ch2, rise only
      filt_len = 4'd0;
      edge_mode = 8'hDF;
      sig[2] = 1'b1;
      ticks(4);
      chk("ovf_pend1", evt_pend, 4'h4);
      chk("ovf_none1", evt_ovf, 4'h0);
      sig[2] = 1'b0;
      ticks(4);
      chk("ovf_fall_masked", evt_ovf, 4'h0);
      sig[2] = 1'b1;
      ticks(4);
      chk("ovf_set", evt_ovf, 4'h4);
      chk("ovf_pend2", evt_pend, 4'h4);
      clr(4'h4);
      chk("ovf_clr_pend", evt_pend, 4'h0);
      chk("ovf_clr_ovf", evt_ovf, 4'h0);
      chk("ovf_clr_irq_hold", irq, 1'b1);
      tick();
      chk("ovf_clr_irq", irq, 1'b0);

      // event and clear in the same cycle on ch3
      sig[3] = 1'b1;
      ticks(4);
      chk("sim_pend", evt_pend, 4'h8);
      sig[3] = 1'b0;
      ticks(4);
      chk("sim_ovf_pre", evt_ovf, 4'h8);
      sig[3] = 1'b1;
      ticks(3);
      chk("sim_rise", rise, 4'h8);
      evt_clr = 4'h8;
      tick();
      evt_clr = 4'h0;
      chk("sim_pend_kept", evt_pend, 4'h8);
      chk("sim_ovf_cleared", evt_ovf, 4'h0);
      clr(4'h8);
      chk("sim_final_clr", evt_pend, 4'h0);

      // ch0 fall-only masking
      edge_mode = 8'hF6;
      sig[0] = 1'b1;
      ticks(3);
      chk("mask_rise_vis", rise, 4'h1);
      tick();
      chk("mask_rise_nopend", evt_pend, 4'h0);
      sig[0] = 1'b0;
      ticks(3);
      chk("mask_fall_vis", fall, 4'h1);
      tick();
      chk("mask_fall_pend", evt_pend, 4'h1);
      clr(4'h1);

      // reset in the middle of a filter count
      filt_len = 4'd5;
      sig[1] = 1'b1;
      ticks(4);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_level", level, 4'h0);
      chk("mid_rst_pend", evt_pend, 4'h0);
      chk("mid_rst_irq", irq, 1'b0);
      sig = 4'h0;
      tick();
      rst_n = 1'b1;
      acc = 4'h0;
      for (int k = 0; k < 20; k++) begin
         tick();
         acc = acc | rise | fall | evt_pend;
      end
      chk("mid_rst_no_pulse", acc, 4'h0);
      chk("mid_rst_level_after", level, 4'h0);

      chk("init_hi_no_edge", b_seen, 4'h0);
      chk("init_hi_level", level_b, 4'hF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
